// File: rtl/mux_sel_arbiter.sv
// Two-requester round-robin arbiter driving the select of a 2:1 mux bank.
// Grants are held for multi-cycle transfers; a hold limit stops one side starving the other.
module mux_sel_arbiter #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CW       = $clog2(HOLD_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          last0,
  input  logic          last1,
  output logic          sel,
  output logic          gnt0,
  output logic          gnt1,
  output logic          busy,
  output logic [CW-1:0] hold_cnt
);

  localparam logic [CW-1:0] HoldMax  = CW'(HOLD_MAX);
  localparam logic [CW-1:0] HoldLast = CW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e          state_q, state_d;
  logic            prio_q, prio_d;
  logic            sel_q, sel_d;
  logic            gnt0_q, gnt0_d;
  logic            gnt1_q, gnt1_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   hold_q, hold_d;
  logic            hold_lim;

  // >= so a waiter that arrives after saturation is served on the next edge
  assign hold_lim = (hold_q >= HoldLast);

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    case (state_q)
      StIdle: begin
        if (req0 && (!req1 || !prio_q)) begin
          state_d = StOwn0;
        end else if (req1) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        if (last0 || !req0 || (hold_lim && req1)) begin
          prio_d  = 1'b1;
          state_d = req1 ? StOwn1 : StIdle;
        end
      end
      StOwn1: begin
        if (last1 || !req1 || (hold_lim && req0)) begin
          prio_d  = 1'b0;
          state_d = req0 ? StOwn0 : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    gnt0_d = (state_d == StOwn0);
    gnt1_d = (state_d == StOwn1);
    busy_d = gnt0_d | gnt1_d;
    // Select is only driven by an owner; idle keeps the last path to avoid toggling
    if (state_d == StOwn1) begin
      sel_d = 1'b1;
    end else if (state_d == StOwn0) begin
      sel_d = 1'b0;
    end else begin
      sel_d = sel_q;
    end

    if (state_d == StIdle) begin
      hold_d = hold_q;
    end else if (state_d != state_q) begin
      hold_d = '0;
    end else if (hold_q == HoldMax) begin
      hold_d = hold_q;
    end else begin
      hold_d = hold_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      prio_q  <= 1'b0;
      sel_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      sel_q   <= sel_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
    end
  end

  assign sel      = sel_q;
  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign busy     = busy_q;
  assign hold_cnt = hold_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter: a HOLD_MAX=8 instance plus a HOLD_MAX=1 instance.
module tb_mux_sel_arbiter;

  logic       clk;
  logic       reset_n;
  logic       req0, req1, last0, last1;
  logic       sel, gnt0, gnt1, busy;
  logic [3:0] hold_cnt;

  logic       b_req0, b_req1, b_last0, b_last1;
  logic       b_sel, b_gnt0, b_gnt1, b_busy;
  logic [0:0] b_hold_cnt;

  int checks   = 0;
  int failures = 0;

  mux_sel_arbiter #(.HOLD_MAX(8)) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req0     (req0),
    .req1     (req1),
    .last0    (last0),
    .last1    (last1),
    .sel      (sel),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .busy     (busy),
    .hold_cnt (hold_cnt)
  );

  mux_sel_arbiter #(.HOLD_MAX(1)) u_dut1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .req0     (b_req0),
    .req1     (b_req1),
    .last0    (b_last0),
    .last1    (b_last1),
    .sel      (b_sel),
    .gnt0     (b_gnt0),
    .gnt1     (b_gnt1),
    .busy     (b_busy),
    .hold_cnt (b_hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic e_sel, input logic e_g0, input logic e_g1,
                         input logic [3:0] e_hold);
    chk({tag, ".sel"}, 32'(sel), 32'(e_sel));
    chk({tag, ".gnt0"}, 32'(gnt0), 32'(e_g0));
    chk({tag, ".gnt1"}, 32'(gnt1), 32'(e_g1));
    chk({tag, ".busy"}, 32'(busy), 32'(e_g0 | e_g1));
    chk({tag, ".hold"}, 32'(hold_cnt), 32'(e_hold));
  endtask

  initial begin
    reset_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; last0 = 1'b0; last1 = 1'b0;
    b_req0 = 1'b1; b_req1 = 1'b1; b_last0 = 1'b0; b_last1 = 1'b0;

    // Reset held with both requests high
    tick(); tick();
    chk_all("reset", 1'b0, 1'b0, 1'b0, 4'd0);

    // Single requester 1, ended by last1
    reset_n = 1'b1; req0 = 1'b0; req1 = 1'b1;
    tick();
    chk_all("own1_e1", 1'b1, 1'b0, 1'b1, 4'd0);
    tick(); chk("own1_e2.hold", 32'(hold_cnt), 32'd1);
    tick(); chk("own1_e3.hold", 32'(hold_cnt), 32'd2);
    tick(); chk("own1_e4.hold", 32'(hold_cnt), 32'd3);
    last1 = 1'b1;
    tick();
    chk_all("idle_after1", 1'b1, 1'b0, 1'b0, 4'd3);
    last1 = 1'b0; req1 = 1'b0;

    // last0 in idle is ignored
    last0 = 1'b1;
    tick();
    chk_all("idle_last0", 1'b1, 1'b0, 1'b0, 4'd3);
    last0 = 1'b0;

    // Tie goes to prio=0, last0 with req1 high swaps without an idle bubble
    req0 = 1'b1; req1 = 1'b1;
    tick(); chk_all("tie_own0", 1'b0, 1'b1, 1'b0, 4'd0);
    tick(); tick();
    chk("tie_hold2", 32'(hold_cnt), 32'd2);
    last0 = 1'b1;
    tick(); chk_all("swap_to1", 1'b1, 1'b0, 1'b1, 4'd0);
    last0 = 1'b0; req1 = 1'b0;

    // req1 drops while req0 waits: direct swap back to OWN0
    tick(); chk_all("swap_to0", 1'b0, 1'b1, 1'b0, 4'd0);

    // Starvation guard: req1 rises at hold_cnt=2, forced release once hold_cnt hits 7
    tick(); tick();
    chk("guard_hold2", 32'(hold_cnt), 32'd2);
    req1 = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk_all("guard_hold7", 1'b0, 1'b1, 1'b0, 4'd7);
    tick();
    chk_all("guard_swap", 1'b1, 1'b0, 1'b1, 4'd0);

    // Back to OWN0, then no contention for 20 cycles: saturates at 8
    req1 = 1'b0;
    tick(); chk_all("nocont_start", 1'b0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 20; i++) tick();
    chk_all("nocont_sat", 1'b0, 1'b1, 1'b0, 4'd8);
    req1 = 1'b1;
    tick();
    chk_all("sat_swap", 1'b1, 1'b0, 1'b1, 4'd0);
    tick();
    chk("own1_hold1", 32'(hold_cnt), 32'd1);

    // Asynchronous reset mid-OWN1, checked before the next clock edge
    #2 reset_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 1'b0, 4'd0);
    chk("async_rst.b_sel", 32'(b_sel), 32'd0);
    chk("async_rst.b_busy", 32'(b_busy), 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk_all("rst_held", 1'b0, 1'b0, 1'b0, 4'd0);

    // HOLD_MAX=1 with both requests constant: ownership alternates 0,1,0,1...
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("hm1_e%0d.sel", k), 32'(b_sel), 32'((k - 1) % 2));
      chk($sformatf("hm1_e%0d.gnt0", k), 32'(b_gnt0), 32'(k % 2));
      chk($sformatf("hm1_e%0d.gnt1", k), 32'(b_gnt1), 32'((k - 1) % 2));
      chk($sformatf("hm1_e%0d.busy", k), 32'(b_busy), 32'd1);
      chk($sformatf("hm1_e%0d.hold", k), 32'(b_hold_cnt), 32'd0);
    end
    chk_all("main_idle_end", 1'b0, 1'b0, 1'b0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
